// File: rtl/tea_pkg.sv
// Shared TEA constants, FSM state and mode types, and the TEA mixing function.
package tea_pkg;

  localparam logic [31:0]  TEA_DELTA       = 32'h9E37_79B9;
  localparam logic [127:0] TEA_DEFAULT_KEY = 128'h95A8882C_9D2CC113_815AA0CD_A1C489F7;

  localparam logic [1:0] STATUS_NONE    = 2'd0;
  localparam logic [1:0] STATUS_ENC_DONE = 2'd1;
  localparam logic [1:0] STATUS_DEC_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } mode_e;

  // F(x,s,ka,kb) = ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb), all mod 2^32
  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] s,
                                        input logic [31:0] ka, input logic [31:0] kb);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_round.sv
// One full TEA cycle (two Feistel half-rounds) for either direction; purely combinational.
module tea_round
  import tea_pkg::*;
#(
  parameter logic [31:0] DELTA = TEA_DELTA
) (
  input  logic [31:0]  v0_i,
  input  logic [31:0]  v1_i,
  input  logic [31:0]  sum_i,
  input  logic [127:0] key_i,
  input  mode_e        mode_i,
  output logic [31:0]  v0_o,
  output logic [31:0]  v1_o,
  output logic [31:0]  sum_o
);

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] s_enc;

  assign k0    = key_i[127:96];
  assign k1    = key_i[95:64];
  assign k2    = key_i[63:32];
  assign k3    = key_i[31:0];
  assign s_enc = sum_i + DELTA;

  // Encrypt updates v0 then v1 with the advanced sum; decrypt undoes v1 then v0 with the current sum.
  always_comb begin
    v0_o  = v0_i;
    v1_o  = v1_i;
    sum_o = sum_i;
    if (mode_i == ENC) begin
      v0_o  = v0_i + tea_f(v1_i, s_enc, k0, k1);
      v1_o  = v1_i + tea_f(v0_o, s_enc, k2, k3);
      sum_o = s_enc;
    end else begin
      v1_o  = v1_i - tea_f(v0_i, sum_i, k2, k3);
      v0_o  = v0_i - tea_f(v1_o, sum_i, k0, k1);
      sum_o = sum_i - DELTA;
    end
  end

endmodule

// File: rtl/tea_round_sched.sv
// Iterative TEA engine: accepts a block, runs ROUNDS cycles through tea_round, holds the result.
module tea_round_sched
  import tea_pkg::*;
#(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = TEA_DELTA
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_we,
  input  logic [127:0] key_wdata,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [31:0]  in_a,
  input  logic [31:0]  in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_a,
  output logic [31:0]  out_b,
  output logic [1:0]   status,
  output logic         busy
);

  localparam int          CNT_W        = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);
  localparam logic [63:0] SUM_DEC_FULL = 64'(DELTA) * 64'(ROUNDS);
  localparam logic [31:0] SUM_DEC      = SUM_DEC_FULL[31:0];

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [31:0]      v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [CNT_W-1:0] rnd_cnt_q, rnd_cnt_d;
  logic [127:0]     key_q, key_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_a_q, out_a_d, out_b_q, out_b_d;
  logic [1:0]       status_q, status_d;
  logic [31:0]      rv0, rv1, rsum;

  tea_round #(.DELTA(DELTA)) u_round (
    .v0_i   (v0_q),
    .v1_i   (v1_q),
    .sum_i  (sum_q),
    .key_i  (key_q),
    .mode_i (mode_q),
    .v0_o   (rv0),
    .v1_o   (rv1),
    .sum_o  (rsum)
  );

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign status    = status_q;

  // Next-state logic: keys only change in IDLE so a running block always sees one key set.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    sum_d       = sum_q;
    rnd_cnt_d   = rnd_cnt_q;
    key_d       = key_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    status_d    = status_q;
    case (state_q)
      IDLE: begin
        if (key_we) key_d = key_wdata;
        if (in_valid) begin
          v0_d      = in_a;
          v1_d      = in_b;
          mode_d    = mode_e'(in_mode);
          sum_d     = in_mode ? SUM_DEC : 32'h0;
          rnd_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        v0_d  = rv0;
        v1_d  = rv1;
        sum_d = rsum;
        if (rnd_cnt_q == LAST_RND) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_a_d     = rv0;
          out_b_d     = rv1;
          status_d    = (mode_q == DEC) ? STATUS_DEC_DONE : STATUS_ENC_DONE;
        end else begin
          rnd_cnt_d = rnd_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          status_d    = STATUS_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, data and key registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= ENC;
      v0_q        <= '0;
      v1_q        <= '0;
      sum_q       <= '0;
      rnd_cnt_q   <= '0;
      key_q       <= TEA_DEFAULT_KEY;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      status_q    <= STATUS_NONE;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      sum_q       <= sum_d;
      rnd_cnt_q   <= rnd_cnt_d;
      key_q       <= key_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      status_q    <= status_d;
    end
  end

endmodule
